mac_match_controller: RTL and testbench

//  Sequences a bank of NUM_MACS mac_comparator instances, one per frame. Holds the

---
 rtl/mac_match_if.sv | 40 ++++
 rtl/mac_match_controller.sv | 169 ++++++++++++++++
 tb/tb_mac_match_controller.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_match_if.sv
// Handshake/config bundle between the MAC match controller and its environment.
// slave = controller side, master = packet path / config / comparator bank side.
interface mac_match_if #(
    parameter int NUM_MACS = 4,
    parameter int COUNT_W  = 16
);
    localparam int IDX_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;

    logic                     cfg_wr_en;
    logic [IDX_W-1:0]         cfg_idx;
    logic [47:0]              cfg_mac;
    logic                     cfg_en;
    logic                     frame_start;
    logic                     data_valid;
    logic                     frame_end;
    logic [NUM_MACS-1:0]      comp_match;
    logic                     comp_clear;
    logic [48*NUM_MACS-1:0]   comp_flagged_mac;
    logic                     verdict_valid;
    logic                     verdict_ready;
    logic                     verdict_hit;
    logic [IDX_W-1:0]         verdict_idx;
    logic                     busy;
    logic [COUNT_W-1:0]       hit_count;
    logic [COUNT_W-1:0]       overrun_count;

    modport master (
        output cfg_wr_en, cfg_idx, cfg_mac, cfg_en,
        output frame_start, data_valid, frame_end, comp_match, verdict_ready,
        input  comp_clear, comp_flagged_mac, verdict_valid, verdict_hit, verdict_idx,
        input  busy, hit_count, overrun_count
    );

    modport slave (
        input  cfg_wr_en, cfg_idx, cfg_mac, cfg_en,
        input  frame_start, data_valid, frame_end, comp_match, verdict_ready,
        output comp_clear, comp_flagged_mac, verdict_valid, verdict_hit, verdict_idx,
        output busy, hit_count, overrun_count
    );
endinterface

// File: rtl/mac_match_controller.sv
// Per-frame sequencer for a bank of MAC comparators; produces one hit/idx verdict per frame.
// Statistics counters are built only when MAC_MATCH_STATS_EN is defined.
//   state  | meaning
//   IDLE   | waiting for frame_start
//   ARM    | comparator clear pulse, shadow -> active table, sticky cleared
//   SCAN   | frame words flowing, sticky accumulates
//   DRAIN  | comparator pipeline draining, sticky accumulates
//   REPORT | verdict held until accepted
module mac_match_controller #(
    parameter int NUM_MACS = 4,
    parameter int PIPE_LAT = 3,
    parameter int COUNT_W  = 16
) (
    input logic        clk,
    input logic        rst,
    mac_match_if.slave bus
);
    localparam int IDX_W = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
    localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        SCAN   = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [47:0]         shadow_mac_q [NUM_MACS];
    logic [NUM_MACS-1:0] shadow_en_q;
    logic [47:0]         active_mac_q [NUM_MACS];
    logic [NUM_MACS-1:0] active_en_q;
    logic [NUM_MACS-1:0] sticky_q, sticky_d, sticky_acc;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hit_q, hit_d;
    logic [IDX_W-1:0]    idx_q, idx_d, low_idx;
    logic                handshake;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_en_q <= '0;
            active_en_q <= '0;
            for (int i = 0; i < NUM_MACS; i++) begin
                shadow_mac_q[i] <= '0;
                active_mac_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_MACS; i++) begin
                if (bus.cfg_wr_en && (bus.cfg_idx == IDX_W'(i))) begin
                    shadow_mac_q[i] <= bus.cfg_mac;
                    shadow_en_q[i]  <= bus.cfg_en;
                end
            end
            // Active table only changes between frames so a frame sees one consistent table.
            if (state_q == ARM) begin
                active_en_q <= shadow_en_q;
                for (int i = 0; i < NUM_MACS; i++) active_mac_q[i] <= shadow_mac_q[i];
            end
        end
    end

    always_comb begin
        bus.comp_flagged_mac = '0;
        for (int i = 0; i < NUM_MACS; i++) bus.comp_flagged_mac[48*i +: 48] = active_mac_q[i];
    end

    assign sticky_acc = sticky_q | (bus.comp_match & active_en_q);

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MACS - 1; i >= 0; i--) begin
            if (sticky_acc[i]) low_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sticky_q <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
        end
    end

    // Drain counter is loaded with PIPE_LAT-1 so REPORT starts PIPE_LAT+1 cycles after frame_end.
    always_comb begin
        state_d  = state_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) state_d = ARM;
            end
            ARM: begin
                sticky_d = '0;
                state_d  = SCAN;
                if (bus.data_valid && bus.frame_end) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(PIPE_LAT - 1);
                end
            end
            SCAN: begin
                sticky_d = sticky_acc;
                if (bus.data_valid && bus.frame_end) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_W'(PIPE_LAT - 1);
                end
            end
            DRAIN: begin
                sticky_d = sticky_acc;
                if (cnt_q == '0) begin
                    state_d = REPORT;
                    hit_d   = |sticky_acc;
                    idx_d   = low_idx;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REPORT: begin
                if (bus.verdict_ready) begin
                    state_d = IDLE;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign handshake         = (state_q == REPORT) && bus.verdict_ready;
    assign bus.comp_clear    = (state_q == ARM);
    assign bus.verdict_valid = (state_q == REPORT);
    assign bus.verdict_hit   = hit_q;
    assign bus.verdict_idx   = idx_q;
    assign bus.busy          = (state_q != IDLE);

`ifdef MAC_MATCH_STATS_EN
    logic [COUNT_W-1:0] hit_cnt_q, ovr_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            if (handshake && hit_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + COUNT_W'(1);
            if (bus.frame_start && (state_q != IDLE) && (ovr_cnt_q != '1))
                ovr_cnt_q <= ovr_cnt_q + COUNT_W'(1);
        end
    end

    assign bus.hit_count     = hit_cnt_q;
    assign bus.overrun_count = ovr_cnt_q;
`else
    logic unused_stats;
    assign unused_stats      = handshake;
    assign bus.hit_count     = '0;
    assign bus.overrun_count = '0;
`endif
endmodule

// File: tb/tb_mac_match_controller.sv
// Randomized self-checking bench for mac_match_controller against a frame-level reference model.
module tb_mac_match_controller;
    localparam int NUM   = 4;
    localparam int PLAT  = 3;
    localparam int CW    = 2;
    localparam int IDX_W = 2;
    localparam int CMAX  = (1 << CW) - 1;
`ifdef MAC_MATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [47:0]    sh_mac [NUM];
    logic [NUM-1:0] sh_en;
    int             m_hit;
    int             m_ovr;

    mac_match_if #(.NUM_MACS(NUM), .COUNT_W(CW)) bus ();

    mac_match_controller #(.NUM_MACS(NUM), .PIPE_LAT(PLAT), .COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cnt(input int v);
        return STATS ? v : 0;
    endfunction

    // First enabled-and-matched entry, scanning upward from index 0.
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM-1:0] v);
        int i;
        i = 0;
        while (i < NUM && !v[i]) i++;
        return (i < NUM) ? IDX_W'(i) : '0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM; i++) sh_mac[i] = '0;
        sh_en = '0;
        m_hit = 0;
        m_ovr = 0;
    endtask

    task automatic cfg_write(input int idx, input logic [47:0] mac, input bit en);
        bus.cfg_idx   = IDX_W'(idx);
        bus.cfg_mac   = mac;
        bus.cfg_en    = en;
        bus.cfg_wr_en = 1'b1;
        sh_mac[idx]   = mac;
        sh_en[idx]    = en;
        tick();
        bus.cfg_wr_en = 1'b0;
    endtask

    // Drives one frame and checks clear pulse, table, latency, verdict and stats.
    // Matches count only after the ARM cycle and up to PIPE_LAT cycles past frame_end.
    task automatic do_frame(input int nwords, input bit rnd, input logic [NUM-1:0] fixed,
                            input int rdly, input bit ovr_wait, input bit ovr_hs,
                            input bit wr_mid, input int wr_idx, input logic [47:0] wr_mac);
        logic [NUM-1:0]       acc, m, act_en;
        logic [48*NUM-1:0]    exp_flag;
        logic [IDX_W-1:0]     exp_idx;
        bit                   exp_hit, dv;
        int                   c, words, f;
        act_en = sh_en;
        for (int i = 0; i < NUM; i++) exp_flag[48*i +: 48] = sh_mac[i];
        acc = '0; words = 0; f = -1;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        c = 1;
        while (f < 0) begin
            dv = (c == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
            bus.data_valid = dv;
            bus.frame_end  = 1'b0;
            if (dv) begin
                words++;
                if (words == nwords) begin
                    bus.frame_end = 1'b1;
                    f = c;
                end
            end else begin
                bus.frame_end = ($urandom_range(0, 4) == 0);
            end
            m = rnd ? NUM'($urandom) : '0;
            bus.comp_match = m;
            if (c >= 2) acc |= m & act_en;
            if (wr_mid && c == 2) begin
                bus.cfg_idx   = IDX_W'(wr_idx);
                bus.cfg_mac   = wr_mac;
                bus.cfg_en    = 1'b1;
                bus.cfg_wr_en = 1'b1;
                sh_mac[wr_idx] = wr_mac;
                sh_en[wr_idx]  = 1'b1;
            end else begin
                bus.cfg_wr_en = 1'b0;
            end
            n_cmp++;
            if (bus.comp_clear !== (c == 1)) begin
                n_bad++;
                $display("FAIL comp_clear c=%0d: got %b expected %b", c, bus.comp_clear, (c == 1));
            end
            n_cmp++;
            if (bus.busy !== 1'b1 || bus.verdict_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL scan_state c=%0d: busy=%b valid=%b expected busy=1 valid=0",
                         c, bus.busy, bus.verdict_valid);
            end
            if (c == 2) begin
                n_cmp++;
                if (bus.comp_flagged_mac !== exp_flag) begin
                    n_bad++;
                    $display("FAIL flagged_scan: got %h expected %h", bus.comp_flagged_mac, exp_flag);
                end
            end
            tick();
            c++;
        end
        bus.data_valid = 1'b0;
        bus.frame_end  = 1'b0;
        bus.cfg_wr_en  = 1'b0;
        for (int k = 1; k <= PLAT; k++) begin
            m = rnd ? NUM'($urandom) : ((k == PLAT) ? fixed : '0);
            bus.comp_match = m;
            acc |= m & act_en;
            n_cmp++;
            if (bus.verdict_valid !== 1'b0 || bus.busy !== 1'b1 || bus.comp_clear !== 1'b0) begin
                n_bad++;
                $display("FAIL drain k=%0d: valid=%b busy=%b clear=%b expected 0 1 0",
                         k, bus.verdict_valid, bus.busy, bus.comp_clear);
            end
            tick();
        end
        exp_hit = |acc;
        exp_idx = first_set(acc);
        bus.comp_match = rnd ? NUM'($urandom) : '0;
        n_cmp++;
        if (bus.verdict_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_valid: got %b expected 1", bus.verdict_valid);
        end
        n_cmp++;
        if (bus.comp_flagged_mac !== exp_flag) begin
            n_bad++;
            $display("FAIL flagged_report: got %h expected %h", bus.comp_flagged_mac, exp_flag);
        end
        for (int w = 0; w <= rdly; w++) begin
            bus.verdict_ready = (w == rdly);
            bus.frame_start   = (w == rdly) ? ovr_hs : (ovr_wait && w == rdly / 2);
            if (bus.frame_start) m_ovr = (m_ovr < CMAX) ? m_ovr + 1 : CMAX;
            n_cmp++;
            if (bus.verdict_valid !== 1'b1 || bus.verdict_hit !== exp_hit ||
                bus.verdict_idx !== exp_idx) begin
                n_bad++;
                $display("FAIL verdict w=%0d: valid=%b hit=%b idx=%0d expected 1 %b %0d",
                         w, bus.verdict_valid, bus.verdict_hit, bus.verdict_idx, exp_hit, exp_idx);
            end
            if (w == rdly && exp_hit) m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
            tick();
            bus.comp_match = rnd ? NUM'($urandom) : '0;
        end
        bus.verdict_ready = 1'b0;
        bus.frame_start   = 1'b0;
        bus.comp_match    = '0;
        n_cmp++;
        if (bus.verdict_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_hs: valid=%b busy=%b expected 0 0", bus.verdict_valid, bus.busy);
        end
        n_cmp++;
        if (bus.hit_count !== CW'(exp_cnt(m_hit)) || bus.overrun_count !== CW'(exp_cnt(m_ovr))) begin
            n_bad++;
            $display("FAIL stats: hit=%0d ovr=%0d expected %0d %0d",
                     bus.hit_count, bus.overrun_count, exp_cnt(m_hit), exp_cnt(m_ovr));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        n_cmp++;
        if (bus.verdict_valid !== 1'b0 || bus.busy !== 1'b0 || bus.comp_clear !== 1'b0 ||
            bus.verdict_hit !== 1'b0 || bus.verdict_idx !== '0 || bus.comp_flagged_mac !== '0 ||
            bus.hit_count !== '0 || bus.overrun_count !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: valid=%b busy=%b clear=%b flagged=%h expected all 0",
                     bus.verdict_valid, bus.busy, bus.comp_clear, bus.comp_flagged_mac);
        end
        rst = 1'b0;
        tick();
        cfg_write(0, 48'h1234_5678_9ABC, 1'b1);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.data_valid  = 1'b1;
        tick();
        bus.comp_match  = 4'b0001;
        tick();
        rst = 1'b1;
        #1;
        bus.data_valid = 1'b0;
        bus.comp_match = '0;
        model_reset();
        n_cmp++;
        if (bus.verdict_valid !== 1'b0 || bus.busy !== 1'b0 || bus.comp_clear !== 1'b0 ||
            bus.verdict_hit !== 1'b0 || bus.comp_flagged_mac !== '0) begin
            n_bad++;
            $display("FAIL reset_midscan: valid=%b busy=%b clear=%b flagged=%h expected all 0",
                     bus.verdict_valid, bus.busy, bus.comp_clear, bus.comp_flagged_mac);
        end
        tick();
        tick();
        rst = 1'b0;
        bus.data_valid = 1'b1;
        bus.frame_end  = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        bus.frame_end  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (bus.verdict_valid !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_verdict i=%0d: valid=%b busy=%b expected 0 0",
                         i, bus.verdict_valid, bus.busy);
            end
            tick();
        end
    endtask

    task automatic test_hit();
        cfg_write(0, 48'hA1B2_C3D4_E5F6, 1'b1);
        do_frame(3, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0, 0, '0);
        do_frame(3, 1'b0, 4'b0000, 1, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_backpressure();
        n_cmp++;
        if (bus.overrun_count !== CW'(exp_cnt(0))) begin
            n_bad++;
            $display("FAIL overrun_before: got %0d expected %0d", bus.overrun_count, exp_cnt(0));
        end
        do_frame(3, 1'b0, 4'b0001, 10, 1'b1, 1'b0, 1'b0, 0, '0);
        n_cmp++;
        if (bus.overrun_count !== CW'(exp_cnt(1))) begin
            n_bad++;
            $display("FAIL overrun_after: got %0d expected %0d", bus.overrun_count, exp_cnt(1));
        end
        do_frame(2, 1'b0, 4'b0001, 2, 1'b0, 1'b1, 1'b0, 0, '0);
    endtask

    task automatic test_priority();
        cfg_write(0, 48'h0, 1'b0);
        cfg_write(1, 48'h0000_0000_1111, 1'b1);
        cfg_write(2, 48'h0000_0000_2222, 1'b0);
        cfg_write(3, 48'h0000_0000_3333, 1'b1);
        do_frame(4, 1'b0, 4'b1110, 0, 1'b0, 1'b0, 1'b0, 0, '0);
        do_frame(3, 1'b0, 4'b0100, 0, 1'b0, 1'b0, 1'b0, 0, '0);
        do_frame(3, 1'b0, 4'b1101, 0, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_shadow();
        cfg_write(0, 48'hA1B2_C3D4_E5F6, 1'b1);
        do_frame(5, 1'b0, 4'b0001, 2, 1'b0, 1'b0, 1'b1, 0, 48'h0000_DEAD_BEEF);
        do_frame(3, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0, 0, '0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) do_frame(2, 1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0, 0, '0);
        n_cmp++;
        if (bus.hit_count !== (STATS ? 2'd3 : 2'd0)) begin
            n_bad++;
            $display("FAIL hit_saturate: got %0d expected %0d", bus.hit_count, STATS ? 3 : 0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            cfg_write($urandom_range(0, NUM - 1), {$urandom, $urandom}, 1'($urandom));
            do_frame($urandom_range(2, 6), 1'b1, '0, $urandom_range(0, 4),
                     1'($urandom), 1'($urandom), 1'b0, 0, '0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_mac = '0;
        bus.cfg_en = 1'b0;
        bus.frame_start = 1'b0;
        bus.data_valid = 1'b0;
        bus.frame_end = 1'b0;
        bus.comp_match = '0;
        bus.verdict_ready = 1'b0;
        test_reset();
        test_hit();
        test_backpressure();
        test_priority();
        test_shadow();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
